// File: rtl/mioc_flop_driver.sv
// mioc_flop_driver: pulse sequencer driving a MIOC open-drain set/reset flop and checking its readback
module mioc_flop_driver #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       rsp_valid,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, RESP} state_t;
  localparam logic [7:0] PL = 8'(PULSE_W - 1);
  localparam logic [7:0] SL = 8'(SETTLE_W - 1);
  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic       q_m_q, qb_m_q, err_d, drv_d;
  // Sequencing through the shared down-counter, plus the readback check against the op's expected q
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q - 8'(cnt_q != 8'd0);
    if (state_q == IDLE && cmd_valid) begin
      op_d = cmd_op;
      state_d = cmd_op == 2'b00 ? SETTLE : PULSE;
      cnt_d = cmd_op == 2'b00 ? SL : PL;
    end else if (state_q == PULSE && cnt_q == 8'd0) begin
      state_d = SETTLE;
      cnt_d = SL;
    end else if (state_q == SETTLE && cnt_q == 8'd0) begin
      state_d = RESP;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    drv_d = state_d == PULSE;
    err_d = (q_m_q == qb_m_q) | (op_q != 2'b00 && q_m_q != (op_q == 2'b01));
  end
  // All outputs are registered from next-state; the response register forms the second synchronizer stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= 2'b00;
      cnt_q <= '0;
      q_m_q <= 1'b0;
      qb_m_q <= 1'b0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      in1 <= 1'b0;
      in2 <= 1'b0;
      in3 <= 1'b1;
      in4 <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q <= 1'b0;
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      q_m_q <= q_fb;
      qb_m_q <= qbar_fb;
      cmd_ready <= state_d == IDLE;
      busy <= state_d != IDLE;
      in1 <= drv_d && op_d == 2'b10;
      in2 <= drv_d && op_d == 2'b11;
      in3 <= !(drv_d && op_d == 2'b11);
      in4 <= drv_d && op_d == 2'b01;
      rsp_valid <= state_d == RESP;
      if (state_d == RESP) begin
        rsp_q <= q_m_q;
        rsp_err <= err_d;
        if (err_d && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mioc_flop_driver.sv
// tb_mioc_flop_driver: scoreboard bench with a behavioural set/reset flop model
module tb_mioc_flop_driver;
  localparam int PW = 4;
  localparam int SW = 2;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic cmd_ready, in1, in2, in3, in4, q_fb, qbar_fb, rsp_valid, rsp_q, rsp_err, busy;
  logic [7:0] err_cnt;
  logic fq = 1'b0;
  int mode = 0;
  int cyc = 0;
  int n_vec = 0, n_mis = 0;
  logic [7:0] exp_cnt = 8'd0;
  typedef struct {int cyc; logic q; logic err; logic [7:0] cnt;} exp_t;
  exp_t sb[$];

  mioc_flop_driver #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // flop model: set on in4 rise, reset on in1 rise or in2 fall; mode 1 = stuck q=1, mode 2 = q=qbar=1
  always @(posedge in4) fq <= 1'b1;
  always @(posedge in1 or negedge in2) fq <= 1'b0;
  assign q_fb = mode == 0 ? fq : 1'b1;
  assign qbar_fb = mode == 0 ? ~fq : mode == 2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send(input logic [1:0] op, input bit push, output int acc);
    exp_t e;
    logic q;
    cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    q = mode != 0 ? 1'b1 : op == 2'b00 ? fq : op == 2'b01;
    e.q = q;
    e.err = (mode == 2) || (op != 2'b00 && q != (op == 2'b01));
    e.cyc = acc + (op == 2'b00 ? SW : PW + SW);
    if (push) begin
      if (e.err && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      e.cnt = exp_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("drv_onehot", 32'({in1, in2, in4} inside {3'b000, 3'b001, 3'b010, 3'b100}), 1);
    chk("in3_inv", 32'(in3 ^ in2), 1);
    if (rsp_valid) begin
      if (sb.size() == 0) chk("spurious_rsp", 32'(rsp_valid), 0);
      else begin
        e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_q", 32'(rsp_q), 32'(e.q));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    int acc, a0, a1, a2;
    repeat (2) @(negedge clk);
    chk("reset_vals", 32'({cmd_ready, busy, in1, in2, in3, in4, rsp_valid, rsp_q, rsp_err, err_cnt}),
        32'({9'b100010000, 8'd0}));
    reset = 1'b0;
    send(2'b01, 1'b1, acc);
    cmd_valid = 1'b0;
    for (int k = 1; k <= PW + 1; k++) begin
      @(negedge clk);
      chk("set_in4", 32'(in4), 32'(k <= PW));
    end
    drain();
    send(2'b11, 1'b1, acc);
    cmd_valid = 1'b0;
    for (int k = 1; k <= PW + 1; k++) begin
      @(negedge clk);
      chk("nrst_in2", 32'(in2), 32'(k <= PW));
      chk("nrst_in3", 32'(in3), 32'(k > PW));
    end
    drain();
    mode = 1;
    send(2'b10, 1'b1, acc);
    cmd_valid = 1'b0;
    drain();
    chk("err_cnt_one", 32'(err_cnt), 1);
    mode = 2;
    send(2'b00, 1'b1, acc);
    cmd_valid = 1'b0;
    for (int k = 1; k <= SW + 1; k++) begin
      @(negedge clk);
      chk("sample_nodrv", 32'({in1, in2, in4}), 0);
    end
    drain();
    mode = 0;
    send(2'b01, 1'b1, a0);
    send(2'b01, 1'b1, a1);
    chk("thru_1", 32'(a1 - a0), PW + SW + 2);
    send(2'b01, 1'b1, a2);
    chk("thru_2", 32'(a2 - a0), 2 * (PW + SW + 2));
    cmd_valid = 1'b0;
    drain();
    mode = 1;
    repeat (299) begin
      send(2'b10, 1'b1, acc);
      cmd_valid = 1'b0;
    end
    drain();
    chk("err_cnt_sat", 32'(err_cnt), 255);
    mode = 0;
    send(2'b01, 1'b0, acc);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_in4_on", 32'(in4), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in4_off", 32'(in4), 0);
    chk("abort_no_rsp", 32'(rsp_valid), 0);
    reset = 1'b0;
    exp_cnt = 8'd0;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_err_cnt", 32'(err_cnt), 0);
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/mioc_flop_driver.md
# mioc_flop_driver

Synchronous stimulus sequencer that drives the four control inputs of a MIOC open-drain set/reset flop and reads its q/qbar outputs back. It accepts set, reset and sample commands over a valid/ready handshake. It produces clean, width-controlled pulses on in1–in4, waits a settle interval, samples the synchronized flop state, and returns a one-cycle response flagging illegal or unexpected states. It sits between test/control logic and the flop, as the transmitter end of the flop's pulse interface.

## Interface
- PULSE_W, 4: pulse high time in clk cycles; legal range 1..255.
- SETTLE_W, 2: settle time after pulse in clk cycles; legal range 2..255. Covers the 2-flop synchronizer.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  2  00 sample, 01 set (in4), 10 posedge reset (in1), 11 negedge reset (in2/in3).
- in1  output  1  flop posedge reset drive.
- in2  output  1  flop negedge reset drive.
- in3  output  1  always ~in2, registered together with in2.
- in4  output  1  flop set drive.
- q_fb, qbar_fb  input  1 each  flop outputs; asynchronous, each through a 2-stage synchronizer.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_q  output  1  synchronized q at sample time.
- rsp_err  output  1  q==qbar, or q differs from expected value.
- busy  output  1  ~cmd_ready.
- err_cnt  output  8  saturating count of rsp_err events.

## Operation
- **States:**
  - IDLE: accept on cmd_valid&cmd_ready; latch op.
  - IDLE → PULSE for ops 01/10/11.
  - IDLE → SETTLE for op 00.
  - PULSE → SETTLE after PULSE_W cycles.
  - SETTLE → RESP after SETTLE_W cycles.
  - RESP → IDLE unconditionally.
- **Idle drive values:** in1=0, in2=0, in3=1, in4=0.
- **PULSE drive:**
  - op 01: in4=1.
  - op 10: in1=1.
  - op 11: in2=1, in3=0. The falling edge of in2 at the end of PULSE is the reset event.
  - Only one drive is ever active at a time.
- **Expected value:**
  - set → q=1.
  - either reset → q=0.
  - sample → no expectation; err only if q==qbar.
- **RESP:**
  - rsp_valid=1 for exactly one cycle.
  - rsp_q and rsp_err registered from the synchronized q_fb/qbar_fb.
  - err_cnt increments if rsp_err, saturating at 255.
- rsp_valid has no backpressure.
- cmd_valid while busy is ignored; the command is neither queued nor acknowledged.
- A single down-counter (8 bit) is shared by PULSE and SETTLE and reloaded on each state entry.

## Timing
- Acceptance edge = cycle 0.
- Drive outputs are high in cycles 1..PULSE_W.
- SETTLE occupies cycles PULSE_W+1..PULSE_W+SETTLE_W.
- rsp_valid is high in cycle PULSE_W+SETTLE_W+1; cmd_ready returns in the next cycle.
- Sample op: rsp_valid in cycle SETTLE_W+1.
- Command throughput: one command per PULSE_W+SETTLE_W+2 cycles; sample op: SETTLE_W+2.
- **Reset values:** state=IDLE, cmd_ready=1, busy=0, in1=0, in2=0, in3=1, in4=0, rsp_valid=0, rsp_q=0, rsp_err=0, err_cnt=0, synchronizers=0.
- **Reset mid-operation:**
  - All drives return to idle values at that edge.
  - No response is issued for the aborted command.
  - err_cnt clears.
- cmd_valid asserted in the RESP cycle is not accepted; cmd_ready is still 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, set op accepted at cycle 0, flop model drives q=1/qbar=0 → in4 high cycles 1–4; rsp_valid at cycle 7 with rsp_q=1, rsp_err=0.
- Op 11 → in2=1 and in3=0 cycles 1–4, in3 back to 1 at cycle 5; rsp_valid at cycle 7 with rsp_q=0, rsp_err=0.
- Op 10 with model stuck at q=1 → rsp_q=1, rsp_err=1, err_cnt=1. Repeat 300 times → err_cnt=255.
- Sample op with model q=qbar=1 → no drive pulse; rsp_valid at cycle 3 with rsp_err=1.
- cmd_valid held high continuously with set ops → accepts at cycles 0, 8, 16; never two drive outputs high at once.
- reset asserted at cycle 2 of a set op → in4=0 at the next edge, no rsp_valid, cmd_ready=1 one cycle after reset deasserts.
